mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_rx_fifo.sv | 58 +++++
 rtl/mmio_ctrl.sv | 156 +++++++++++++++
 tb/tb_mmio_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Register offsets, decode nibble default and TX FSM encoding
//               shared by the mmio_ctrl slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  localparam logic [3:0] MMIO_NIBBLE_DEFAULT = 4'h8;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RXDATA  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CNTCLR  = 8'h18;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/mmio_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_rx_fifo
// Description : Byte FIFO for received UART data; DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule : mmio_rx_fifo
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_ctrl
// Description : MMIO block with UART TX/RX and cycle/instret counters.
//               Define MMIO_RX_FIFO_EN for a RX_FIFO_DEPTH-entry RX FIFO;
//               otherwise RX uses a single-byte holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int         RX_FIFO_DEPTH = 8,
  parameter logic [3:0] MMIO_NIBBLE   = MMIO_NIBBLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic        w_hit;
  logic        w_ld;
  logic        w_st;
  logic [7:0]  w_off;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [31:0] w_rd_mux;
  logic        w_cnt_clr;
  logic        w_tx_accept;
  logic        w_unused;
  tx_state_e   r_tx_state;
  tx_state_e   w_tx_state_nxt;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  assign w_hit     = req_valid && (req_addr[31:28] == MMIO_NIBBLE);
  assign w_off     = req_addr[7:0];
  assign w_ld      = w_hit && !req_we;
  assign w_st      = w_hit && req_we;
  assign w_cnt_clr = w_st && (w_off == OFF_CNTCLR);
  assign w_rx_push = uart_rx_valid && uart_rx_ready;
  assign w_rx_pop  = w_ld && (w_off == OFF_RXDATA) && !w_rx_empty;
  assign uart_rx_ready = !w_rx_full;
  assign w_unused  = ^{req_addr[27:8], req_wdata[31:8]};

`ifdef MMIO_RX_FIFO_EN
  mmio_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_data  (uart_rx_data),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );
`else
  logic r_rx_valid;
  logic [7:0] r_rx_byte;
  logic w_unused_depth;

  assign w_unused_depth = (RX_FIFO_DEPTH > 0);

  // Push and pop are exclusive here: push needs an empty slot, pop a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= 8'h00;
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end else if (w_rx_push) begin
      r_rx_valid <= 1'b1;
      r_rx_byte  <= uart_rx_data;
    end
  end

  assign w_rx_full  = r_rx_valid;
  assign w_rx_empty = !r_rx_valid;
  assign w_rx_head  = r_rx_byte;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_accept    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_st && (w_off == OFF_TXDATA)) begin
          w_tx_accept    = 1'b1;
          w_tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (uart_tx_ready) w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign uart_tx_valid = (r_tx_state == TX_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              uart_tx_data <= 8'h00;
    else if (w_tx_accept) uart_tx_data <= req_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt   <= r_cycle_cnt + 32'd1;
      if (inst_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_STATUS:  w_rd_mux = {30'b0, !w_rx_empty, (r_tx_state == TX_IDLE)};
      OFF_RXDATA:  w_rd_mux = w_rx_empty ? 32'h0 : {24'b0, w_rx_head};
      OFF_CYCLE:   w_rd_mux = r_cycle_cnt;
      OFF_INSTRET: w_rd_mux = r_instret_cnt;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata <= '0;
    else if (w_ld) rdata <= w_rd_mux;
  end

endmodule : mmio_ctrl
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_ctrl
// Description : Directed self-checking bench for mmio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_ctrl;

`ifdef MMIO_RX_FIFO_EN
  localparam int TB_DEPTH = 8;
`else
  localparam int TB_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata;
  logic        inst_retire = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int hs_cnt  = 0;

  mmio_ctrl #(
    .RX_FIFO_DEPTH (8),
    .MMIO_NIBBLE   (4'h8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rdata         (rdata),
    .inst_retire   (inst_retire),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && uart_tx_valid && uart_tx_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_load(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = {4'h8, 20'h0, off}; req_wdata = '0;
    @(posedge clk); #1;
    d = rdata;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [3:0] nib, input logic [7:0] off, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = {nib, 20'h0, off}; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk); #1;
    vectors++;
    if (rdata !== 32'h0 || uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00 || uart_rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h txv=%b txd=%h rxr=%b, want 0 0 00 1",
               rdata, uart_tx_valid, uart_tx_data, uart_rx_ready);
    end
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    do_load(8'h10, d);
    vectors++;
    if (d < 32'd9 || d > 32'd11) begin
      errors++; $display("FAIL cycle_after_reset: got %0d want 10 (+/-1)", d);
    end
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_after_reset: got %h want 1", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    int hs0;
    uart_tx_ready = 1'b0;
    do_store(4'h8, 8'h08, 32'hFFFF_FF41);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
        errors++; $display("FAIL tx_hold[%0d]: txv=%b txd=%h want 1 41", i, uart_tx_valid, uart_tx_data);
      end
      @(posedge clk); #1;
    end
    do_store(4'h8, 8'h08, 32'h42);
    vectors++;
    if (uart_tx_data !== 8'h41 || uart_tx_valid !== 1'b1) begin
      errors++; $display("FAIL tx_drop: txv=%b txd=%h want 1 41", uart_tx_valid, uart_tx_data);
    end
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_busy: got %h want 0", d); end
    hs0 = hs_cnt;
    @(negedge clk); uart_tx_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_release: txv=%b want 0", uart_tx_valid); end
    repeat (3) @(posedge clk);
    @(negedge clk); uart_tx_ready = 1'b0;
    vectors++;
    if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL tx_handshakes: got %0d want 1", hs_cnt - hs0); end
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_after_tx: got %h want 1", d); end
  endtask

  task automatic test_fifo();
    logic [31:0] d;
    for (int i = 0; i < TB_DEPTH; i++) begin
      vectors++;
      if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_fill[%0d]: got %b want 1", i, uart_rx_ready); end
      push_byte(8'((i + 1) * 8'h11));
    end
    vectors++;
    if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full: rx_ready=%b want 0", uart_rx_ready); end
    push_byte(8'hEE);
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h3) begin errors++; $display("FAIL status_full: got %h want 3", d); end
    for (int i = 0; i < TB_DEPTH; i++) begin
      do_load(8'h04, d);
      vectors++;
      if (d !== 32'((i + 1) * 8'h11)) begin
        errors++; $display("FAIL rx_order[%0d]: got %h want %h", i, d, 32'((i + 1) * 8'h11));
      end
    end
    do_load(8'h04, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_underflow: got %h want 0", d); end
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_drained: got %h want 1", d); end
  endtask

  task automatic test_simul();
    logic [31:0] d;
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0; req_valid = 1'b0;
    vectors++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL simul_empty: got %h want 0", rdata); end
    do_load(8'h04, d);
    vectors++;
    if (d !== 32'h5A) begin errors++; $display("FAIL simul_next: got %h want 5a", d); end
    for (int i = 0; i < TB_DEPTH; i++) push_byte(8'(8'h30 + i));
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0; req_valid = 1'b0;
    vectors++;
    if (rdata !== 32'h30 || uart_rx_ready !== 1'b1) begin
      errors++; $display("FAIL simul_full: rdata=%h rxr=%b want 30 1", rdata, uart_rx_ready);
    end
    for (int i = 1; i < TB_DEPTH; i++) do_load(8'h04, d);
    do_load(8'h04, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL simul_full_nopush: got %h want 0", d); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    do_store(4'h8, 8'h18, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); inst_retire = 1'b1;
      @(negedge clk); inst_retire = 1'b0;
    end
    do_load(8'h14, d);
    vectors++;
    if (d !== 32'd7) begin errors++; $display("FAIL instret_7: got %0d want 7", d); end
    @(negedge clk); inst_retire = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0018; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; inst_retire = 1'b0;
    do_load(8'h14, d);
    vectors++;
    if (d !== 32'd0) begin errors++; $display("FAIL instret_clear: got %0d want 0", d); end
    do_load(8'h10, d);
    vectors++;
    if (d !== 32'd1) begin errors++; $display("FAIL cycle_clear: got %0d want 1", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] held;
    do_store(4'h7, 8'h08, 32'h66);
    vectors++;
    if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL nonhit_store: txv=%b want 0", uart_tx_valid); end
    do_store(4'h8, 8'h0C, 32'h99);
    vectors++;
    if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL other_store: txv=%b want 0", uart_tx_valid); end
    do_load(8'h0C, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL other_load: got %h want 0", d); end
    do_load(8'h10, held);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h7000_0014;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (rdata !== held) begin errors++; $display("FAIL rdata_hold: got %h want %h", rdata, held); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    uart_tx_ready = 1'b0;
    do_store(4'h8, 8'h08, 32'h55);
    for (int i = 0; i < ((TB_DEPTH < 3) ? TB_DEPTH : 3); i++) push_byte(8'(8'hA0 + i));
    vectors++;
    if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: txv=%b want 1", uart_tx_valid); end
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1 || uart_tx_data !== 8'h00 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: txv=%b rxr=%b txd=%h rdata=%h want 0 1 00 0",
               uart_tx_valid, uart_rx_ready, uart_tx_data, rdata);
    end
    @(negedge clk); rst = 1'b0;
    do_load(8'h00, d);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_post_reset: got %h want 1", d); end
    do_load(8'h04, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_post_reset: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_fifo();
    test_simul();
    test_counters();
    test_decode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_mmio_ctrl
`default_nettype wire
